// File: rtl/des_ctrl.sv
// -----------------------------------------------------------------------------
// des_ctrl
//
// Control sequencer between the DES data register FIFO and the DES round
// datapath. When the data register signals a complete 64-bit block
// (full_pulse), the block is loaded into the datapath. The datapath is then
// stepped through ROUNDS rounds with the subkey index for encrypt or decrypt.
// The result is written back to the data register, and done/irq status is
// raised for the register file. The block also owns the data register's
// pointer-clear strobe, which is pulsed when an abort is requested.
//
// Ports
//   hclk, hresetn   clock, asynchronous active-low reset
//   ctrl_en         engine enable (only gates acceptance of a new block)
//   mode_dec        1 = decrypt, 0 = encrypt; latched in LOAD
//   key_ready       key schedule valid
//   full_pulse      one-cycle "block available" strobe from the data register
//   q_all[63:0]     data register contents {word1, word0}
//   abort           synchronous abort request (pulse or level)
//   irq_clr         clears irq and ovf_err
//   core_dout[63:0] round datapath result
//   core_load       load core_din into the datapath
//   core_din[63:0]  block to the datapath (zero outside LOAD)
//   core_round_en   advance the datapath by one round
//   round_idx[3:0]  subkey index for the current round
//   decrypt         latched mode for the datapath
//   deswr           write data_all into the data register
//   data_all[63:0]  result block (zero outside WB)
//   clrptr          active-low pointer clear to the data register
//   busy            sequencer not idle
//   done            one-cycle completion pulse
//   irq             sticky completion interrupt
//   ovf_err         sticky: full_pulse arrived while busy
// -----------------------------------------------------------------------------
module des_ctrl #(
    parameter int ROUNDS = 16
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        ctrl_en,
    input  logic        mode_dec,
    input  logic        key_ready,
    input  logic        full_pulse,
    input  logic [63:0] q_all,
    input  logic        abort,
    input  logic        irq_clr,
    input  logic [63:0] core_dout,
    output logic        core_load,
    output logic [63:0] core_din,
    output logic        core_round_en,
    output logic [3:0]  round_idx,
    output logic        decrypt,
    output logic        deswr,
    output logic [63:0] data_all,
    output logic        clrptr,
    output logic        busy,
    output logic        done,
    output logic        irq,
    output logic        ovf_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WKEY  = 3'd1,
        S_LOAD  = 3'd2,
        S_ROUND = 3'd3,
        S_WB    = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Index of the final round; the round counter stops here instead of
    // wrapping, so a 17th round can never be issued.
    localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);

    state_t     state_q, state_d;
    logic [3:0] rcnt_q, rcnt_d;
    logic       decrypt_q, decrypt_d;
    logic       irq_q, irq_d;
    logic       ovf_q, ovf_d;
    logic       clrptr_q, clrptr_d;
    logic       abort_q, abort_d;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q   <= S_IDLE;
            rcnt_q    <= 4'd0;
            decrypt_q <= 1'b0;
            irq_q     <= 1'b0;
            ovf_q     <= 1'b0;
            clrptr_q  <= 1'b1;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            decrypt_q <= decrypt_d;
            irq_q     <= irq_d;
            ovf_q     <= ovf_d;
            clrptr_q  <= clrptr_d;
            abort_q   <= abort_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rcnt_d        = rcnt_q;
        decrypt_d     = decrypt_q;
        core_load     = 1'b0;
        core_din      = 64'd0;
        core_round_en = 1'b0;
        round_idx     = 4'd0;
        deswr         = 1'b0;
        data_all      = 64'd0;
        done          = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A block offered while disabled is silently dropped.
                if (full_pulse && ctrl_en) begin
                    state_d = key_ready ? S_LOAD : S_WKEY;
                end
            end
            S_WKEY: begin
                if (key_ready) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                core_load = 1'b1;
                core_din  = q_all;
                decrypt_d = mode_dec;
                rcnt_d    = 4'd0;
                state_d   = S_ROUND;
            end
            S_ROUND: begin
                core_round_en = 1'b1;
                // Decrypt consumes the key schedule in reverse order.
                round_idx     = decrypt_q ? (LAST_RND - rcnt_q) : rcnt_q;
                if (rcnt_q == LAST_RND) begin
                    state_d = S_WB;
                end else begin
                    rcnt_d = rcnt_q + 4'd1;
                end
            end
            S_WB: begin
                // An abort arriving in this very cycle must not corrupt
                // the data register, so the write strobe is suppressed.
                deswr    = !abort;
                data_all = core_dout;
                state_d  = S_DONE;
            end
            S_DONE: begin
                done    = !abort;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides every transition, including acceptance in IDLE.
        if (abort) begin
            state_d = S_IDLE;
            rcnt_d  = 4'd0;
        end
    end

    // Sticky status: clear first so a same-cycle set wins. irq is set on
    // the WB->DONE transition so it is visible together with done.
    always_comb begin
        irq_d = irq_q;
        ovf_d = ovf_q;
        if (irq_clr) begin
            irq_d = 1'b0;
            ovf_d = 1'b0;
        end
        if (state_q == S_WB && !abort) begin
            irq_d = 1'b1;
        end
        if (full_pulse && state_q != S_IDLE) begin
            ovf_d = 1'b1;
        end
    end

    // Pointer clear fires once on the rising edge of abort, so a level
    // abort still produces a single-cycle strobe.
    always_comb begin
        abort_d  = abort;
        clrptr_d = !(abort && !abort_q);
    end

    assign decrypt = decrypt_q;
    assign busy    = (state_q != S_IDLE);
    assign irq     = irq_q;
    assign ovf_err = ovf_q;
    assign clrptr  = clrptr_q;

endmodule

// File: tb/tb_des_ctrl.sv
module tb_des_ctrl;

    logic        hclk;
    logic        hresetn;
    logic        ctrl_en;
    logic        mode_dec;
    logic        key_ready;
    logic        full_pulse;
    logic [63:0] q_all;
    logic        abort;
    logic        irq_clr;
    logic [63:0] core_dout;
    logic        core_load;
    logic [63:0] core_din;
    logic        core_round_en;
    logic [3:0]  round_idx;
    logic        decrypt;
    logic        deswr;
    logic [63:0] data_all;
    logic        clrptr;
    logic        busy;
    logic        done;
    logic        irq;
    logic        ovf_err;

    int checks = 0;
    int errors = 0;

    // Model of the sticky status bits as seen by software.
    bit irq_exp = 0;
    bit ovf_exp = 0;

    des_ctrl #(.ROUNDS(16)) dut (
        .hclk          (hclk),
        .hresetn       (hresetn),
        .ctrl_en       (ctrl_en),
        .mode_dec      (mode_dec),
        .key_ready     (key_ready),
        .full_pulse    (full_pulse),
        .q_all         (q_all),
        .abort         (abort),
        .irq_clr       (irq_clr),
        .core_dout     (core_dout),
        .core_load     (core_load),
        .core_din      (core_din),
        .core_round_en (core_round_en),
        .round_idx     (round_idx),
        .decrypt       (decrypt),
        .deswr         (deswr),
        .data_all      (data_all),
        .clrptr        (clrptr),
        .busy          (busy),
        .done          (done),
        .irq           (irq),
        .ovf_err       (ovf_err)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // One block from pulse to return to IDLE. Cycle "off" is the off-th
    // clock period after the edge that samples full_pulse.
    //   kd  : number of WKEY cycles (key_ready first sampled high at end of cycle kd)
    //   ab  : cycle in which abort is driven (0 = none)
    //   xp  : cycle in which an extra full_pulse is driven (0 = none)
    //   clr : cycle in which irq_clr is driven (0 = none)
    task automatic run_block(input bit dec, input int kd, input int ab,
                             input int xp, input int clr, input string nm);
        logic [63:0] blk;
        logic [63:0] res;
        int          last;
        blk = {$urandom, $urandom};
        res = {$urandom, $urandom};
        full_pulse = 1'b1;
        ctrl_en    = 1'b1;
        q_all      = blk;
        core_dout  = res;
        mode_dec   = dec;
        key_ready  = (kd == 0);
        abort      = 1'b0;
        irq_clr    = 1'b0;
        last = (ab > 0) ? ab + 2 : kd + 20;
        for (int off = 1; off <= last; off++) begin
            bit          gone;
            bit          in_wkey, in_load, in_round, in_wb, in_done, e_busy;
            int          r;
            logic [3:0]  e_idx;
            logic [11:0] e_vec;
            logic [11:0] a_vec;
            logic [63:0] e_din;
            logic [63:0] e_dall;
            @(negedge hclk);
            gone     = (ab > 0) && (off > ab);
            r        = off - kd - 2;
            in_wkey  = !gone && off <= kd;
            in_load  = !gone && off == kd + 1;
            in_round = !gone && off >= kd + 2 && off <= kd + 17;
            in_wb    = !gone && off == kd + 18;
            in_done  = !gone && off == kd + 19;
            e_busy   = in_wkey | in_load | in_round | in_wb | in_done;
            e_idx    = in_round ? 4'(dec ? 15 - r : r) : 4'd0;
            e_din    = in_load ? blk : 64'd0;
            e_dall   = in_wb ? res : 64'd0;
            e_vec = {in_load, in_round, e_idx, in_wb, e_busy, in_done,
                     irq_exp, ovf_exp, !((ab > 0) && off == ab + 1)};
            a_vec = {core_load, core_round_en, round_idx, deswr, busy, done,
                     irq, ovf_err, clrptr};
            checks++;
            if (a_vec !== e_vec) begin
                errors++;
                $display("FAIL %s ctl cycle %0d: got load/rnd/idx/wr/busy/done/irq/ovf/clrp=%b required %b",
                         nm, off, a_vec, e_vec);
            end
            checks++;
            if (core_din !== e_din || data_all !== e_dall) begin
                errors++;
                $display("FAIL %s data cycle %0d: core_din=%h data_all=%h required %h %h",
                         nm, off, core_din, data_all, e_din, e_dall);
            end
            if (in_round || in_wb) begin
                checks++;
                if (decrypt !== dec) begin
                    errors++;
                    $display("FAIL %s decrypt cycle %0d: got %b required %b", nm, off, decrypt, dec);
                end
            end
            // Status update at the end of this cycle.
            if (off == clr) begin
                irq_exp = 0;
                ovf_exp = 0;
            end
            if (in_wb) irq_exp = 1;
            if (off == xp && e_busy) ovf_exp = 1;
            // Stimulus for the rest of this cycle.
            full_pulse = (off == xp);
            key_ready  = (off >= kd);
            abort      = (off == ab);
            irq_clr    = (off == clr);
            ctrl_en    = $urandom_range(0, 1);
            if (off > kd + 1) q_all = {$urandom, $urandom};
            if (in_round) mode_dec = $urandom_range(0, 1);
        end
        full_pulse = 1'b0;
        abort      = 1'b0;
        irq_clr    = 1'b0;
        ctrl_en    = 1'b1;
    endtask

    task automatic check_reset_values(input string nm);
        checks++;
        if ({core_load, core_round_en, round_idx, decrypt, deswr, busy, done,
             irq, ovf_err, clrptr} !== 13'b0000000000001 ||
            core_din !== 64'd0 || data_all !== 64'd0) begin
            errors++;
            $display("FAIL %s: load=%b rnd=%b idx=%h dec=%b wr=%b busy=%b done=%b irq=%b ovf=%b clrp=%b din=%h dall=%h required all 0 except clrptr=1",
                     nm, core_load, core_round_en, round_idx, decrypt, deswr, busy,
                     done, irq, ovf_err, clrptr, core_din, data_all);
        end
    endtask

    task automatic test_reset();
        hresetn    = 1'b0;
        ctrl_en    = 1'b0;
        mode_dec   = 1'b0;
        key_ready  = 1'b0;
        full_pulse = 1'b0;
        q_all      = 64'd0;
        abort      = 1'b0;
        irq_clr    = 1'b0;
        core_dout  = 64'd0;
        repeat (3) @(negedge hclk);
        check_reset_values("reset");
        hresetn = 1'b1;
        @(negedge hclk);
        check_reset_values("after_reset");
    endtask

    task automatic test_encrypt();
        run_block(1'b0, 0, 0, 0, 0, "encrypt");
    endtask

    task automatic test_decrypt();
        run_block(1'b1, 0, 0, 0, 0, "decrypt");
    endtask

    task automatic test_back_to_back();
        run_block($urandom_range(0, 1), 0, 0, 0, 0, "b2b_first");
        run_block($urandom_range(0, 1), 0, 0, 0, 0, "b2b_second");
    endtask

    task automatic test_key_wait();
        run_block(1'b0, 5, 0, 0, 0, "key_wait");
    endtask

    task automatic test_abort();
        run_block(1'b0, 0, 2 + 7, 0, 0, "abort_round7");
        run_block(1'b1, 3, 2, 0, 0, "abort_wkey");
    endtask

    // Extra pulse at rcnt=3, irq_clr in the WB cycle (set must win for irq).
    task automatic test_overflow();
        run_block(1'b0, 0, 0, 2 + 3, 18, "overflow");
    endtask

    task automatic test_irq_clr();
        irq_clr = 1'b1;
        @(negedge hclk);
        irq_clr = 1'b0;
        irq_exp = 0;
        ovf_exp = 0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (irq !== 1'b0 || ovf_err !== 1'b0) begin
                errors++;
                $display("FAIL irq_clr %0d: irq=%b ovf_err=%b required 0 0", i, irq, ovf_err);
            end
            @(negedge hclk);
        end
    endtask

    task automatic test_idle_abort();
        ctrl_en    = 1'b0;
        key_ready  = 1'b1;
        full_pulse = 1'b1;
        @(negedge hclk);
        full_pulse = 1'b0;
        checks++;
        if (busy !== 1'b0 || ovf_err !== ovf_exp) begin
            errors++;
            $display("FAIL disabled_pulse: busy=%b ovf_err=%b required 0 %b", busy, ovf_err, ovf_exp);
        end
        abort = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge hclk);
            checks++;
            if (clrptr !== (i != 1) || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_abort %0d: clrptr=%b busy=%b required %b 0", i, clrptr, busy, (i != 1));
            end
            if (i == 3) abort = 1'b0;
        end
        ctrl_en = 1'b1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            run_block($urandom_range(0, 1), $urandom_range(0, 3), 0, 0, 0, "random");
        end
    endtask

    // Reset asserted in the last ROUND cycle, i.e. the cycle before WB.
    task automatic test_reset_mid_wb();
        q_all      = {$urandom, $urandom};
        core_dout  = {$urandom, $urandom};
        mode_dec   = 1'b0;
        key_ready  = 1'b1;
        ctrl_en    = 1'b1;
        full_pulse = 1'b1;
        for (int off = 1; off <= 17; off++) begin
            @(negedge hclk);
            full_pulse = 1'b0;
            checks++;
            if (deswr !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL pre_reset cycle %0d: deswr=%b busy=%b required 0 1", off, deswr, busy);
            end
        end
        hresetn = 1'b0;
        #1;
        check_reset_values("reset_mid_op");
        @(negedge hclk);
        check_reset_values("reset_mid_op_held");
        hresetn = 1'b1;
        irq_exp = 0;
        ovf_exp = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge hclk);
            checks++;
            if ({deswr, busy, done, clrptr} !== 4'b0001) begin
                errors++;
                $display("FAIL post_reset %0d: deswr/busy/done/clrptr=%b required 0001",
                         i, {deswr, busy, done, clrptr});
            end
        end
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_back_to_back();
        test_key_wait();
        test_abort();
        test_overflow();
        test_irq_clr();
        test_idle_abort();
        test_random();
        test_reset_mid_wb();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
